sync_fifo_hs: RTL and testbench
===============================

SYNC_FIFO_HS -- requirements
Module: sync_fifo_hs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, log2 of FIFO depth (DEPTH = 16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-003 SHALL have parameter AFULL_THRESH, default 12, count at or above which almost_full asserts.
REQ-004 SHALL have port aclk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all contents.
REQ-007 SHALL have port s_valid, input, 1, write side: data offered.
REQ-008 SHALL have port s_ready, output, 1, write side: space available.
REQ-009 SHALL have port s_data, input, DATA_WIDTH, write side: payload.
REQ-010 SHALL have port m_valid, output, 1, read side: data available.
REQ-011 SHALL have port m_ready, input, 1, read side: consumer accepts.
REQ-012 SHALL have port m_data, output, DATA_WIDTH, read side: head-of-queue payload.
REQ-013 SHALL have port count, output, ADDR_WIDTH+1, current occupancy 0..DEPTH.
REQ-014 SHALL have port almost_full, output, 1, count >= AFULL_THRESH.
REQ-015 SHALL have port overflow, output, 1, sticky: s_valid seen while full.
REQ-016 SHALL have port underflow, output, 1, sticky: m_ready seen while empty.

Function
REQ-017 SHALL define push = s_valid & s_ready and pop = m_valid & m_ready; only these move data.
REQ-018 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH+1 bits; low bits address storage, MSB is wrap bit.
REQ-019 SHALL flag empty when wr_ptr == rd_ptr, and full when low bits are equal and MSBs differ.
REQ-020 SHALL drive s_ready = !full and m_valid = !empty, both combinationally from registered pointers.
REQ-021 SHALL present m_data = storage[rd_ptr low bits] combinationally (first-word fall-through).
REQ-022 SHALL make a pushed word visible on m_valid/m_data the cycle after push (latency 1).
REQ-023 SHALL, on push, write s_data at wr_ptr and increment wr_ptr modulo 2^(ADDR_WIDTH+1).
REQ-024 SHALL, on pop, increment rd_ptr modulo 2^(ADDR_WIDTH+1).
REQ-025 SHALL maintain count registered: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-026 SHALL allow simultaneous push and pop at any non-full, non-empty occupancy, leaving count unchanged.
REQ-027 SHALL, when full, refuse push even if pop occurs in the same cycle (s_ready is not pop-dependent).
REQ-028 SHALL, when empty, never bypass s_data to m_data in the same cycle.
REQ-029 SHALL register almost_full from next-state count, so it matches count every cycle.
REQ-030 SHALL set overflow when s_valid & full and underflow when m_ready & empty; cleared only by reset or flush.
REQ-031 SHALL give flush priority over push and pop: pointers, count and sticky flags go to 0 next cycle; stored data zeroed.
REQ-032 SHALL produce s_ready = 1 and m_valid = 0 the cycle after flush.

Reset
REQ-033 SHALL on aresetn low at a rising edge set wr_ptr, rd_ptr, count = 0 and almost_full, overflow, underflow = 0.
REQ-034 SHALL give s_ready = 1, m_valid = 0 and m_data = 0 after reset, with storage zeroed.
REQ-035 SHALL discard any in-flight push or pop in a cycle where reset is applied mid-operation.

Structure
REQ-036 SHALL instantiate sync_fifo_ram as the sole sub-module, with its aresetn tied high and srst = !aresetn | flush.
REQ-037 SHALL drive the sync_fifo_ram ports wr_en = push, addr_in = wr_ptr low bits and addr_out = rd_ptr low bits.
REQ-038 SHALL keep no shared-package types; the only derived local constant is DEPTH = 1 << ADDR_WIDTH.

Verification
REQ-039 Fill test: reset, push 0x0001..0x0010 with m_ready=0 -> count=16, s_ready=0, almost_full=1 from count 12.
REQ-040 Drain test: from full, m_ready=1 -> m_data sequence 0x0001..0x0010, then m_valid=0 and count=0.
REQ-041 Streaming test: push and pop every cycle for 40 cycles at count 5 -> count stays 5, order preserved across pointer wrap.
REQ-042 Error flags test: s_valid=1 while full -> overflow=1 and data unchanged; m_ready=1 while empty -> underflow=1.
REQ-043 Flush test: at count 9 assert flush with s_valid=1 and m_ready=1 -> next cycle count=0, m_valid=0, flags=0, word not stored.
REQ-044 Reset test: deassert aresetn at count 7 mid-stream -> next edge gives count=0, s_ready=1, m_data=0.

Source files
------------

// File: rtl/sync_fifo_hs_pkg.sv
// Shared helpers for the sync_fifo_hs handshake FIFO.
// Holds no types; only the threshold compare used for almost_full.
package sync_fifo_hs_pkg;

   function automatic logic at_or_above(input int unsigned value, input int unsigned thresh);
      return (value >= thresh);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_hs: synchronous write, combinational read.
// srst clears every word so a reset or flushed FIFO presents zero at its head.
module sync_fifo_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Word write; clear has priority so an in-flight write is dropped.
   always_ff @(posedge aclk) begin
      if (!aresetn || srst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en) begin
         mem_r[addr_in] <= data_in;
      end
   end

   assign data_out = mem_r[addr_out];

endmodule

// File: rtl/sync_fifo_hs.sv
// Single-clock valid/ready FIFO with first-word fall-through read,
// registered occupancy, almost_full and sticky overflow/underflow flags.
module sync_fifo_hs
   import sync_fifo_hs_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned AFULL_THRESH = 12
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   logic [ADDR_WIDTH:0] wr_ptr_r;
   logic [ADDR_WIDTH:0] rd_ptr_r;
   logic [ADDR_WIDTH:0] count_r;
   logic [ADDR_WIDTH:0] count_nxt_s;
   logic                almost_full_r;
   logic                overflow_r;
   logic                underflow_r;
   logic                empty_s;
   logic                full_s;
   logic                push_s;
   logic                pop_s;
   logic                ram_srst_s;

   // Wrap bit distinguishes full from empty when the address bits match.
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);

   assign s_ready    = !full_s;
   assign m_valid    = !empty_s;
   assign push_s     = s_valid && s_ready;
   assign pop_s      = m_valid && m_ready;
   assign ram_srst_s = !aresetn || flush;

   // Next occupancy, shared by the count register and almost_full.
   always_comb begin
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = {(ADDR_WIDTH+1){1'b0}};
      end else if (push_s && !pop_s) begin
         count_nxt_s = count_r + (ADDR_WIDTH+1)'(1'b1);
      end else if (!push_s && pop_s) begin
         count_nxt_s = count_r - (ADDR_WIDTH+1)'(1'b1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Pointers, occupancy and status flags; flush clears like reset.
   always_ff @(posedge aclk) begin
      if (!aresetn || flush) begin
         wr_ptr_r      <= {(ADDR_WIDTH+1){1'b0}};
         rd_ptr_r      <= {(ADDR_WIDTH+1){1'b0}};
         count_r       <= {(ADDR_WIDTH+1){1'b0}};
         almost_full_r <= 1'b0;
         overflow_r    <= 1'b0;
         underflow_r   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + (ADDR_WIDTH+1)'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (ADDR_WIDTH+1)'(1'b1);
         end
         count_r       <= count_nxt_s;
         almost_full_r <= at_or_above(32'(count_nxt_s), AFULL_THRESH);
         if (s_valid && full_s) begin
            overflow_r <= 1'b1;
         end
         if (m_ready && empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   assign count       = count_r;
   assign almost_full = almost_full_r;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;

   sync_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .aclk     (aclk),
      .aresetn  (1'b1),
      .srst     (ram_srst_s),
      .wr_en    (push_s),
      .addr_in  (wr_ptr_r[ADDR_WIDTH-1:0]),
      .data_in  (s_data),
      .addr_out (rd_ptr_r[ADDR_WIDTH-1:0]),
      .data_out (m_data)
   );

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Scoreboard bench for sync_fifo_hs: a queue model predicts status outputs,
// and a separate monitor checks every word the FIFO hands out, in order.
module tb_sync_fifo_hs;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          flush;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [AW:0]   count;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_q [$];
   bit            ovf_m = 1'b0;
   bit            unf_m = 1'b0;

   sync_fifo_hs #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .AFULL_THRESH (AFT)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .flush       (flush),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive, compare status with the model, then advance the model.
   task automatic step(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl, input bit rn);
      int  sz;
      bit  full_m;
      bit  empty_m;
      @(negedge aclk);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush   = fl;
      aresetn = rn;
      #1;
      sz = model_q.size();
      chk("count",       32'(count),       32'(sz));
      chk("s_ready",     32'(s_ready),     32'(sz < DEPTH));
      chk("m_valid",     32'(m_valid),     32'(sz != 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AFT));
      chk("overflow",    32'(overflow),    32'(ovf_m));
      chk("underflow",   32'(underflow),   32'(unf_m));
      if (!rn || fl) begin
         model_q.delete();
         exp_q.delete();
         ovf_m = 1'b0;
         unf_m = 1'b0;
      end else begin
         full_m  = (sz == DEPTH);
         empty_m = (sz == 0);
         if (sv && full_m) ovf_m = 1'b1;
         if (mr && empty_m) unf_m = 1'b1;
         if (mr && !empty_m) void'(model_q.pop_front());
         if (sv && !full_m) begin
            model_q.push_back(sd);
            exp_q.push_back(sd);
         end
      end
   endtask

   // Monitor: whenever the DUT completes a read, the word must match the scoreboard head.
   always @(negedge aclk) begin
      logic [DW-1:0] e;
      #2;
      if (aresetn === 1'b1 && flush === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_pop: got 0x%0h expected no word", m_data);
         end else begin
            e = exp_q.pop_front();
            chk("m_data_order", 32'(m_data), 32'(e));
         end
      end
   end

   initial begin
      aresetn = 1'b0;
      flush   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_data  = 16'h0000;
      repeat (3) @(posedge aclk);

      // reset state
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("m_data_after_reset", 32'(m_data), 32'h0);

      // fill 0x0001..0x0010, then offer one more while full
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("full_head", 32'(m_data), 32'h0001);

      // drain, then read while empty
      for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // flush at count 9 with a push and pop offered
      for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("m_data_after_flush", 32'(m_data), 32'h0);

      // streaming at count 5 across pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);

      // reset mid-stream at count 7
      for (int i = 0; i < 2; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("m_data_after_midreset", 32'(m_data), 32'h0);

      // random traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 49) == 0), 1'b1);
      end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
